// File: rtl/sam_con_frame_sink.sv
// Receive side of the SAM_Con output stream: buffers Last-delimited words in a
// first-word fall-through FIFO and tracks frame length, completion and overflow.
module sam_con_frame_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LEN_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [DATA_WIDTH-1:0]   Data_In,
  input  logic                    Data_Valid,
  input  logic                    Last_Data_In,
  output logic [DATA_WIDTH-1:0]   Rd_Data,
  output logic                    Rd_Last,
  output logic                    Rd_Valid,
  input  logic                    Rd_Ready,
  output logic [$clog2(DEPTH):0]  Fill,
  output logic [LEN_W-1:0]        Frame_Len,
  output logic                    Frame_Done,
  output logic                    Drop_Frame,
  output logic                    Overflow,
  input  logic                    Clr_Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_C  = (AW+1)'(DEPTH);
  localparam logic [LEN_W-1:0]  CNT_MAX = {LEN_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fill_q, fill_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d, len_q, len_d, cnt_inc_s;
  logic                  done_q, done_d, drop_q, drop_d, ovf_q, ovf_d;
  logic                  pop_s, accept_s, push_s, ovf_set_s;

  // A full FIFO can still accept a word when the head is popped the same cycle.
  assign pop_s    = (fill_q != (AW+1)'(0)) & Rd_Ready;
  assign accept_s = (fill_q != FULL_C) | pop_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    if (state_q == CAPTURE) begin
      cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);
    end else begin
      cnt_inc_s = LEN_W'(1);
    end
    if (Data_Valid) begin
      case (state_q)
        IDLE, CAPTURE: begin
          if (accept_s) begin
            push_s = 1'b1;
            if (Last_Data_In) begin
              state_d = IDLE;
              len_d   = cnt_inc_s;
              done_d  = 1'b1;
              cnt_d   = LEN_W'(0);
            end else begin
              state_d = CAPTURE;
              cnt_d   = cnt_inc_s;
            end
          end else begin
            ovf_set_s = 1'b1;
            cnt_d     = LEN_W'(0);
            if (Last_Data_In) begin
              state_d = IDLE;
              drop_d  = 1'b1;
            end else begin
              state_d = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (Last_Data_In) begin
            state_d = IDLE;
            drop_d  = 1'b1;
          end else begin
            state_d = DISCARD;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = LEN_W'(0);
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (Clr_Overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      fill_q   <= (AW+1)'(0);
      cnt_q    <= LEN_W'(0);
      len_q    <= LEN_W'(0);
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read while Fill says they are valid.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {Last_Data_In, Data_In};
    end
  end

  assign Rd_Valid   = (fill_q != (AW+1)'(0));
  assign Rd_Data    = Rd_Valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign Rd_Last    = Rd_Valid & mem_q[rd_ptr_q][DATA_WIDTH];
  assign Fill       = fill_q;
  assign Frame_Len  = len_q;
  assign Frame_Done = done_q;
  assign Drop_Frame = drop_q;
  assign Overflow   = ovf_q;

endmodule
